// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
//   chunk_w          : bits handled by one pipeline stage (WIDTH/STAGES)
//   groups_per_chunk : lookahead groups of BLOCK bits inside one stage
//   cfg_ok           : elaboration-time legality check of a parameter set
package cla_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 2;
    localparam int DEF_BLOCK  = 4;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int groups_per_chunk(input int width, input int stages, input int block);
        return width / (stages * block);
    endfunction

    function automatic bit cfg_ok(input int width, input int stages, input int block);
        return (stages >= 1) && (block >= 1) && (width >= stages * block) &&
               ((width % (stages * block)) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group.
//   a, b   : group operands
//   cin    : carry into the group
//   sum    : group sum bits
//   gp, gg : group propagate / generate (both independent of cin)
//   c_msb  : carry into the group's most significant bit
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             gp,
    output logic             gg,
    output logic             c_msb
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;

    assign p  = a ^ b;
    assign g  = a & b;
    assign gp = &p;

    // gp/gg are kept in logic that never sees cin, so the second-level
    // lookahead that feeds cin back from them forms no combinational loop.
    always_comb begin : gen_chain
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            acc = g[i] | (p[i] & acc);
        end
        gg = acc;
    end

    always_comb begin : carry_chain
        logic carry;
        carry = cin;
        sum   = '0;
        c_msb = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = p[i] ^ carry;
            if (i == BLOCK - 1) begin
                c_msb = carry;
            end
            carry = g[i] | (p[i] & carry);
        end
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : operand handshake
//   in_a, in_b, in_cin, in_sub   : operands, carry/borrow in, 1 = subtract
//   out_valid/out_ready          : result handshake
//   out_sum, out_cout, out_ovf   : result, raw carry-out, signed overflow
//   out_gp, out_gg               : word group propagate / generate
// Rank 0 registers the prepared operands; rank k+1 holds the result of
// stage k, so a transfer accepted on edge N is visible after edge N+STAGES.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int BLOCK  = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_gp,
    output logic             out_gg
);

    localparam int C = chunk_w(WIDTH, STAGES);
    localparam int G = groups_per_chunk(WIDTH, STAGES, BLOCK);
    localparam logic [WIDTH-1:0] CHUNK_ONES = WIDTH'({C{1'b1}});

    if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_bad_cfg
        $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK");
    end

    // Pipeline ranks 0..STAGES; a/b carry the not-yet-added upper bits,
    // s accumulates finished low sum bits.
    logic             v_q  [STAGES+1];
    logic [WIDTH-1:0] a_q  [STAGES+1];
    logic [WIDTH-1:0] b_q  [STAGES+1];
    logic [WIDTH-1:0] s_q  [STAGES+1];
    logic             c_q  [STAGES+1];
    logic             gp_q [STAGES+1];
    logic             gg_q [STAGES+1];
    logic             cm_q [STAGES+1];

    logic [C-1:0]     cs_nx [STAGES];
    logic             c_nx  [STAGES];
    logic             gp_nx [STAGES];
    logic             gg_nx [STAGES];
    logic             cm_nx [STAGES];

    logic stall;

    assign stall    = v_q[STAGES] & ~out_ready;
    assign in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [G-1:0] grp_p;
        logic [G-1:0] grp_g;
        logic [G-1:0] grp_cm;
        logic [G:0]   grp_c;
        logic [C-1:0] chunk_sum;
        logic         ch_gp;
        logic         ch_gg;
        logic         unused_cm;

        for (genvar j = 0; j < G; j++) begin : g_grp
            cla_block #(.BLOCK(BLOCK)) u_blk (
                .a     (a_q[k][k*C + j*BLOCK +: BLOCK]),
                .b     (b_q[k][k*C + j*BLOCK +: BLOCK]),
                .cin   (grp_c[j]),
                .sum   (chunk_sum[j*BLOCK +: BLOCK]),
                .gp    (grp_p[j]),
                .gg    (grp_g[j]),
                .c_msb (grp_cm[j])
            );
        end

        // Second-level lookahead across the groups of this chunk.
        always_comb begin
            grp_c[0] = c_q[k];
            ch_gp    = 1'b1;
            ch_gg    = 1'b0;
            for (int j = 0; j < G; j++) begin
                grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
                ch_gg      = grp_g[j] | (grp_p[j] & ch_gg);
                ch_gp      = ch_gp & grp_p[j];
            end
        end

        // Only the top group's MSB carry matters (word overflow, last stage).
        assign unused_cm = ^grp_cm;

        assign cs_nx[k] = chunk_sum;
        assign c_nx[k]  = grp_c[G];
        assign gp_nx[k] = ch_gp;
        assign gg_nx[k] = ch_gg;
        assign cm_nx[k] = grp_cm[G-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= STAGES; i++) begin
                v_q[i]  <= 1'b0;
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                s_q[i]  <= '0;
                c_q[i]  <= 1'b0;
                gp_q[i] <= 1'b0;
                gg_q[i] <= 1'b0;
                cm_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            v_q[0]  <= in_valid;
            a_q[0]  <= in_a;
            b_q[0]  <= in_sub ? ~in_b : in_b;
            c_q[0]  <= in_sub ^ in_cin;
            s_q[0]  <= '0;
            gp_q[0] <= 1'b1;
            gg_q[0] <= 1'b0;
            cm_q[0] <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1]  <= v_q[k];
                a_q[k+1]  <= a_q[k];
                b_q[k+1]  <= b_q[k];
                s_q[k+1]  <= (s_q[k] & ~(CHUNK_ONES << (k*C))) |
                             (WIDTH'(cs_nx[k]) << (k*C));
                c_q[k+1]  <= c_nx[k];
                gp_q[k+1] <= gp_q[k] & gp_nx[k];
                gg_q[k+1] <= gg_nx[k] | (gp_nx[k] & gg_q[k]);
                cm_q[k+1] <= cm_nx[k];
            end
        end
    end

    assign out_valid = v_q[STAGES];
    assign out_sum   = s_q[STAGES];
    assign out_cout  = c_q[STAGES];
    assign out_ovf   = c_q[STAGES] ^ cm_q[STAGES];
    assign out_gp    = gp_q[STAGES];
    assign out_gg    = gg_q[STAGES];

endmodule
